// File: rtl/regfl_loader.sv
// Byte-stream loader for the 8 x 64-bit register file: packs NB bytes per word
// (first byte lands in the low byte) and writes words into consecutive slots from a base index.
module regfl_loader #(
    parameter int BW = 8,
    parameter int NB = 8,
    parameter int AW = 3,
    localparam int DW = BW * NB
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base,
    input  logic [AW:0]     nwords,
    input  logic            abort,
    input  logic [BW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            we,
    output logic [AW-1:0]   s,
    output logic [DW-1:0]   d,
    output logic            busy,
    output logic            done
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [AW:0]   rem;
    logic          accept;
    logic          last_byte;

    assign accept    = (state == COLLECT) && in_valid && !abort;
    assign last_byte = (cnt == CW'(NB - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort wins over any same-cycle byte accept or write follow-up
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (nwords != (AW + 1)'(0)) ? COLLECT : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && last_byte) begin
                    state_next = WRITE;
                end else begin
                    state_next = COLLECT;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (rem == (AW + 1)'(1)) begin
                    state_next = DONE;
                end else begin
                    state_next = COLLECT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready = 1'b0;
        we       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: request latch, byte packing, slot index and remaining-word count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            rem <= '0;
            s   <= '0;
            d   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= base;
                        rem <= nwords;
                        cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        cnt <= '0;
                    end else if (accept) begin
                        d   <= {in_data, d[DW-1:BW]};
                        cnt <= last_byte ? CW'(0) : cnt + CW'(1);
                        // s only moves when a word is about to be written
                        if (last_byte) begin
                            s <= idx;
                        end
                    end
                end
                WRITE: begin
                    idx <= idx + AW'(1);
                    rem <= rem - (AW + 1)'(1);
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule
